// File: rtl/ysyx_25070198_ifu_fetch.sv
// Multi-cycle instruction fetch: one word request per instruction, valid/ready handoff to IDU,
// next PC computed on EXU commit. Optional perf counters under `IFU_PERF_CNT_EN.
module ysyx_25070198_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rerr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        fault,
  input  logic        commit,
  input  logic        jump,
  input  logic [31:0] jump_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {FETCH, WAIT, SEND, EXEC} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic        fault_reg, fault_next;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    fault_next = fault_reg;
    case (state_reg)
      FETCH: if (mem_gnt) state_next = WAIT;
      WAIT: begin
        if (mem_rvalid) begin
          inst_next  = mem_rerr ? INST_NOP : mem_rdata;
          fault_next = mem_rerr;
          state_next = SEND;
        end
      end
      SEND: if (out_ready) state_next = EXEC;
      EXEC: begin
        if (commit) begin
          pc_next    = jump ? {jump_pc[31:2], 2'b00} : pc_reg + 32'd4;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'd0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      fault_reg <= fault_next;
    end
  end

  // Handshake outputs are masked while reset is held so nothing leaks out mid-reset.
  assign mem_req   = rst && (state_reg == FETCH);
  assign mem_addr  = {pc_reg[31:2], 2'b00};
  assign out_valid = rst && (state_reg == SEND);
  assign pc        = pc_reg;
  assign inst      = inst_reg;
  assign fault     = fault_reg;

  logic unused_jump_lsb;
  assign unused_jump_lsb = ^jump_pc[1:0];

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg, stall_cnt_reg;
  logic        fetch_inc, stall_inc;

  assign fetch_inc = (state_reg == WAIT) && mem_rvalid;
  assign stall_inc = ((state_reg == FETCH) && !mem_gnt) || ((state_reg == WAIT) && !mem_rvalid);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_reg <= 32'd0;
      stall_cnt_reg <= 32'd0;
    end else begin
      if (fetch_inc) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (stall_inc) stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ysyx_25070198_ifu_fetch.sv
// Directed bench for ysyx_25070198_ifu_fetch; walks each state with hand-computed expectations.
// Perf counter checks are compiled in only when IFU_PERF_CNT_EN is defined.
module tb_ysyx_25070198_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_rerr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        fault;
  logic        commit = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_pc = 32'd0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  int          exp_fetch = 0;
  int          exp_stall = 0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int cyc_mark;

  ysyx_25070198_ifu_fetch dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .inst(inst), .fault(fault),
    .commit(commit), .jump(jump), .jump_pc(jump_pc)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // FETCH: hold gnt low for gnt_wait cycles, request must stay stable, then grant.
  task automatic fetch_phase(input int gnt_wait, input logic [31:0] exp_addr);
    for (int i = 0; i < gnt_wait; i++) begin
      check_val("fetch_req_hold", {31'd0, mem_req}, 32'd1);
      check_val("fetch_addr_hold", mem_addr, exp_addr);
      tick();
    end
    check_val("fetch_req", {31'd0, mem_req}, 32'd1);
    check_val("fetch_addr", mem_addr, exp_addr);
    cyc_mark = cyc;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
`ifdef IFU_PERF_CNT_EN
    exp_stall += gnt_wait;
`endif
  endtask

  // WAIT: no response for rv_wait cycles (inst must not move), then respond.
  task automatic wait_phase(input int rv_wait, input logic [31:0] rdata, input logic err,
                            input logic [31:0] prev_inst);
    for (int i = 0; i < rv_wait; i++) begin
      check_val("wait_req_low", {31'd0, mem_req}, 32'd0);
      check_val("wait_inst_held", inst, prev_inst);
      tick();
    end
    check_val("wait_no_valid", {31'd0, out_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    mem_rerr   = err;
    tick();
    mem_rvalid = 1'b0;
    mem_rerr   = 1'b0;
    mem_rdata  = 32'h0BAD_0BAD;
`ifdef IFU_PERF_CNT_EN
    exp_stall += rv_wait;
    exp_fetch += 1;
`endif
  endtask

  // SEND: stall ready for ready_wait cycles with an optional spurious commit, then accept.
  task automatic send_phase(input int ready_wait, input logic [31:0] exp_pc, input logic [31:0] exp_inst,
                            input logic exp_fault, input logic spurious);
    for (int i = 0; i < ready_wait; i++) begin
      check_val("send_valid_hold", {31'd0, out_valid}, 32'd1);
      check_val("send_pc_hold", pc, exp_pc);
      check_val("send_inst_hold", inst, exp_inst);
      commit  = spurious;
      jump    = spurious;
      jump_pc = 32'h1234_5678;
      tick();
      commit = 1'b0;
      jump   = 1'b0;
    end
    check_val("send_valid", {31'd0, out_valid}, 32'd1);
    check_val("send_pc", pc, exp_pc);
    check_val("send_inst", inst, exp_inst);
    check_val("send_fault", {31'd0, fault}, {31'd0, exp_fault});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // EXEC: idle commit_wait cycles (pc must hold), then commit.
  task automatic exec_phase(input int commit_wait, input logic j, input logic [31:0] jpc,
                            input logic [31:0] exp_pc);
    for (int i = 0; i < commit_wait; i++) begin
      check_val("exec_pc_hold", pc, exp_pc);
      tick();
    end
    check_val("exec_valid_low", {31'd0, out_valid}, 32'd0);
    commit  = 1'b1;
    jump    = j;
    jump_pc = jpc;
    tick();
    commit  = 1'b0;
    jump    = 1'b0;
    jump_pc = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_pc", pc, 32'h8000_0000);
    check_val("rst_inst", inst, 32'd0);
    check_val("rst_fault", {31'd0, fault}, 32'd0);
    rst = 1'b1;
    #1;

    // 1: all handshakes immediate, 4-cycle loop
    fetch_phase(0, 32'h8000_0000);
    wait_phase(0, 32'h0010_0093, 1'b0, 32'd0);
    send_phase(0, 32'h8000_0000, 32'h0010_0093, 1'b0, 1'b0);
    exec_phase(0, 1'b0, 32'd0, 32'h8000_0000);
    check_val("loop_cycles", cyc - cyc_mark, 32'd4);

    // 2: three cycles without gnt, two WAIT cycles without rvalid
    fetch_phase(3, 32'h8000_0004);
    wait_phase(2, 32'h0020_0113, 1'b0, 32'h0010_0093);
`ifdef IFU_PERF_CNT_EN
    check_val("perf_stall", perf_stall_cnt, exp_stall);
    check_val("perf_stall_delta5", exp_stall, 32'd5);
    check_val("perf_fetch", perf_fetch_cnt, exp_fetch);
`endif

    // 3: ready stalled 4 cycles with spurious commits, then pc holds until real commit
    send_phase(4, 32'h8000_0004, 32'h0020_0113, 1'b0, 1'b1);
    exec_phase(3, 1'b1, 32'h8000_0102, 32'h8000_0004);

    // 4: jump target is word-aligned
    fetch_phase(0, 32'h8000_0100);

    // 5: errored fetch presents NOP with fault, next clean fetch clears it
    wait_phase(0, 32'hDEAD_BEEF, 1'b1, 32'h0020_0113);
    send_phase(0, 32'h8000_0100, 32'h0000_0013, 1'b1, 1'b0);
    exec_phase(0, 1'b0, 32'd0, 32'h8000_0100);
    fetch_phase(0, 32'h8000_0104);
    wait_phase(0, 32'h0030_0193, 1'b0, 32'h0000_0013);
    send_phase(0, 32'h8000_0104, 32'h0030_0193, 1'b0, 1'b0);

    // 6a: reset while in WAIT
    exec_phase(0, 1'b1, 32'h0000_0400, 32'h8000_0104);
    fetch_phase(0, 32'h0000_0400);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
`ifdef IFU_PERF_CNT_EN
    exp_fetch = 0;
    exp_stall = 0;
    check_val("perf_fetch_rst", perf_fetch_cnt, exp_fetch);
`endif
    check_val("rst6_req", {31'd0, mem_req}, 32'd1);
    check_val("rst6_addr", mem_addr, 32'h8000_0000);
    check_val("rst6_valid", {31'd0, out_valid}, 32'd0);

    // 6b: jump to top of address space, sequential commit wraps to 0
    fetch_phase(0, 32'h8000_0000);
    wait_phase(0, 32'h0000_0013, 1'b0, 32'd0);
    send_phase(0, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0);
    exec_phase(0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
    fetch_phase(0, 32'hFFFF_FFFC);
    wait_phase(0, 32'h0040_0213, 1'b0, 32'h0000_0013);
    send_phase(0, 32'hFFFF_FFFC, 32'h0040_0213, 1'b0, 1'b0);
    exec_phase(0, 1'b0, 32'd0, 32'hFFFF_FFFC);
    check_val("wrap_addr", mem_addr, 32'd0);
    check_val("wrap_pc", pc, 32'd0);
`ifdef IFU_PERF_CNT_EN
    check_val("perf_fetch_end", perf_fetch_cnt, exp_fetch);
    check_val("perf_stall_end", perf_stall_cnt, exp_stall);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_25070198_ifu_fetch.md
Name: ysyx_25070198_ifu_fetch

Overview:
Multi-cycle instruction fetch stage. It replaces the combinational DPI-C fetch path with a request/response memory port and a valid/ready handoff to the decode stage.
- Holds the architectural PC and issues one word fetch per instruction.
- Buffers the returned word and presents {pc, inst} to IDU.
- Waits for the EXU commit (jump/jump_pc) before computing the next PC.
- Non-pipelined: at most one instruction is in flight.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
INST_NOP, 32'h0000_0013, word presented on a fetch bus error (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous reset, active-low (0 = reset)
mem_req  output  1  fetch request valid
mem_addr  output  32  fetch byte address, bits[1:0] always 0
mem_gnt  input  1  memory accepts request this cycle
mem_rvalid  input  1  response data valid
mem_rdata  input  32  response instruction word
mem_rerr  input  1  response bus error, qualified by mem_rvalid
out_valid  output  1  {pc,inst} valid to IDU
out_ready  input  1  IDU accepts
pc  output  32  PC of current instruction
inst  output  32  current instruction word
fault  output  1  current inst came from an errored fetch
commit  input  1  EXU finished current instruction (1-cycle pulse)
jump  input  1  redirect, qualified by commit
jump_pc  input  32  redirect target, qualified by commit & jump

Behaviour:
- States: FETCH, WAIT, SEND, EXEC. All regs update on posedge clk.
- Reset (rst==0 at a posedge): state=FETCH, pc=RESET_PC, inst=0, fault=0, mem_req=0, out_valid=0. Reset mid-operation abandons any state. The memory shares rst, so no stale response follows.
- FETCH:
  - mem_req=1, mem_addr=pc.
  - mem_gnt=1 -> WAIT. Otherwise stay; mem_req and mem_addr stay stable.
- WAIT:
  - mem_req=0.
  - mem_rvalid=1 -> latch inst (mem_rdata, or INST_NOP if mem_rerr) and fault=mem_rerr -> SEND.
  - mem_rvalid is never asserted in the same cycle as mem_gnt. Minimum fetch latency is gnt cycle + 1.
- SEND:
  - out_valid=1.
  - pc, inst, fault are held stable while out_valid & !out_ready.
  - out_ready=1 -> EXEC.
- EXEC:
  - out_valid=0; pc, inst, fault are held.
  - commit=1 -> pc <= jump ? {jump_pc[31:2],2'b00} : pc+32'd4 (mod 2^32, 32'hFFFF_FFFC+4 wraps to 0) -> FETCH.
- Ignored inputs:
  - commit outside EXEC.
  - mem_rvalid outside WAIT.
  - mem_gnt outside FETCH.
- Simultaneous events: commit arriving in the same cycle as the SEND handshake is ignored. EXU must pulse at least one cycle after accept.
- Throughput: best case 4 cycles per instruction (FETCH+WAIT+SEND+EXEC) with gnt, rvalid, ready and commit each immediate.
- ebreak detection remains in top. The block does not decode.

Optional Feature:
IFU_PERF_CNT_EN:
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on every WAIT->SEND transition.
  - perf_stall_cnt increments each cycle in FETCH with mem_gnt=0 or WAIT with mem_rvalid=0.
  - Both counters wrap at 2^32.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then immediate gnt/rvalid(rdata=32'h00100093)/ready/commit(jump=0):
   - first mem_addr=32'h8000_0000;
   - out_valid with pc=32'h8000_0000, inst=32'h00100093;
   - next mem_addr=32'h8000_0004;
   - 4-cycle loop.
2. Hold mem_gnt=0 for 3 cycles, then rvalid 2 cycles after gnt:
   - mem_req and mem_addr stable throughout;
   - inst latched only on rvalid;
   - perf_stall_cnt=5 (with IFU_PERF_CNT_EN).
3. out_ready=0 for 4 cycles in SEND:
   - out_valid, pc, inst unchanged;
   - spurious commit during the stall ignored;
   - pc unchanged after eventual accept until a real commit.
4. Commit with jump=1, jump_pc=32'h8000_0102:
   - next mem_addr=32'h8000_0100.
5. rvalid with mem_rerr=1, rdata=32'hDEADBEEF:
   - inst=32'h0000_0013, fault=1;
   - next clean fetch clears fault to 0.
6. Assert rst=0 during WAIT:
   - next cycle state FETCH, mem_addr=32'h8000_0000, out_valid=0.
   - Separately, pc=32'hFFFF_FFFC with commit, jump=0 -> mem_addr=0.
